// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Single-beat data bus between the load/store unit and memory.
//  Revision    : 1.0
// ============================================================================
interface load_store_unit_if;
    logic [31:0] bus_addr_out;
    logic        bus_read_out;
    logic        bus_write_out;
    logic [31:0] bus_wdata_out;
    logic [3:0]  bus_wmask_out;
    logic [31:0] bus_rdata_in;
    logic        bus_ready_in;
    logic        bus_fault_in;

    modport master (
        output bus_addr_out, bus_read_out, bus_write_out, bus_wdata_out, bus_wmask_out,
        input  bus_rdata_in, bus_ready_in, bus_fault_in
    );

    modport slave (
        input  bus_addr_out, bus_read_out, bus_write_out, bus_wdata_out, bus_wmask_out,
        output bus_rdata_in, bus_ready_in, bus_fault_in
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory-stage load/store engine, one outstanding bus beat.
//  Revision    : 1.0
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        mem_width_in,
    input  logic              mem_zero_extend_in,
    input  logic              mem_fence_in,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic              stall_out,
    output logic [31:0]       rdata_out,
    output logic              rdata_valid_out,
    output logic              misaligned_out,
    output logic              fault_out,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        r_is_byte;
    logic        r_is_half;
    logic        r_zext;
    logic [1:0]  r_off;
    logic        r_is_write;
    logic        r_bus_read;
    logic        r_bus_write;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_req;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load;
    logic        w_unused_fence;

    // A fence never has anything to wait for in IDLE, so it needs no logic.
    assign w_unused_fence = mem_fence_in;

    assign w_req        = valid_in & (mem_read_in | mem_write_in);
    assign w_is_byte    = (mem_width_in == 3'd0);
    assign w_is_half    = (mem_width_in == 3'd1);
    assign w_is_word    = ~(w_is_byte | w_is_half);
    assign w_misaligned = (w_is_half & addr_in[0]) | (w_is_word & (addr_in[1:0] != 2'b00));
    assign w_accept     = (r_state == S_IDLE) & w_req & ~w_misaligned;
    assign w_timeout    = (r_count == c_timeout_last);

    assign w_wmask = w_is_byte ? (4'b0001 << addr_in[1:0]) :
                     w_is_half ? (4'b0011 << {addr_in[1], 1'b0}) : 4'b1111;
    assign w_wdata = w_is_byte ? {4{wdata_in[7:0]}} :
                     w_is_half ? {2{wdata_in[15:0]}} : wdata_in;

    assign w_lane = bus.bus_rdata_in >> {r_off, 3'b000};
    assign w_load = r_is_byte ? (r_zext ? {24'd0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]}) :
                    r_is_half ? (r_zext ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]}) :
                    w_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        stall_out       = 1'b0;
        misaligned_out  = 1'b0;
        rdata_valid_out = 1'b0;
        rdata_out       = 32'd0;
        fault_out       = 1'b0;
        case (r_state)
            S_IDLE: begin
                misaligned_out = w_req & w_misaligned;
                stall_out      = w_accept;
                if (w_accept) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_out = 1'b1;
                if (bus.bus_ready_in | w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rdata_valid_out = 1'b1;
                rdata_out       = r_rdata;
                fault_out       = r_fault;
                w_next_state    = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 8'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wmask     <= 4'd0;
            r_is_byte   <= 1'b0;
            r_is_half   <= 1'b0;
            r_zext      <= 1'b0;
            r_off       <= 2'd0;
            r_is_write  <= 1'b0;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_rdata     <= 32'd0;
            r_fault     <= 1'b0;
        end else if (w_accept) begin
            // Write wins when read and write arrive together.
            r_count     <= 8'd0;
            r_addr      <= {addr_in[31:2], 2'b00};
            r_wdata     <= w_wdata;
            r_wmask     <= mem_write_in ? w_wmask : 4'd0;
            r_is_byte   <= w_is_byte;
            r_is_half   <= w_is_half;
            r_zext      <= mem_zero_extend_in;
            r_off       <= addr_in[1:0];
            r_is_write  <= mem_write_in;
            r_bus_read  <= ~mem_write_in;
            r_bus_write <= mem_write_in;
        end else if (r_state == S_BUSY) begin
            if (bus.bus_ready_in) begin
                r_bus_read  <= 1'b0;
                r_bus_write <= 1'b0;
                r_fault     <= bus.bus_fault_in;
                r_rdata     <= (bus.bus_fault_in | r_is_write) ? 32'd0 : w_load;
            end else if (w_timeout) begin
                r_bus_read  <= 1'b0;
                r_bus_write <= 1'b0;
                r_fault     <= 1'b1;
                r_rdata     <= 32'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.bus_addr_out  = r_addr;
    assign bus.bus_read_out  = r_bus_read;
    assign bus.bus_write_out = r_bus_write;
    assign bus.bus_wdata_out = r_wdata;
    assign bus.bus_wmask_out = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed and random checks of load_store_unit against a model.
//  Revision    : 1.0
// ============================================================================
module tb_load_store_unit;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [2:0]  mem_width_in = 3'd0;
    logic        mem_zero_extend_in = 1'b0;
    logic        mem_fence_in = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        rdata_valid_out;
    logic        misaligned_out;
    logic        fault_out;

    int checks = 0;
    int errors = 0;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk                (clk),
        .reset              (reset),
        .valid_in           (valid_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .mem_width_in       (mem_width_in),
        .mem_zero_extend_in (mem_zero_extend_in),
        .mem_fence_in       (mem_fence_in),
        .addr_in            (addr_in),
        .wdata_in           (wdata_in),
        .stall_out          (stall_out),
        .rdata_out          (rdata_out),
        .rdata_valid_out    (rdata_valid_out),
        .misaligned_out     (misaligned_out),
        .fault_out          (fault_out),
        .bus                (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] w);
        return (w == 3'd0) ? 1 : (w == 3'd1) ? 2 : 4;
    endfunction

    // Reference load result from plain arithmetic on byte counts.
    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [2:0] w, input bit z);
        longint sz, off, v;
        sz  = size_of(w);
        off = a % 4;
        v   = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * sz));
        if (sz < 4 && !z && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic [3:0] exp_mask(input logic [31:0] a, input logic [2:0] w);
        logic [3:0] m;
        int off;
        m = 4'd0;
        off = int'(a % 4);
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + size_of(w)) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] w);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = d[8*(k % size_of(w)) +: 8];
        return r;
    endfunction

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_rd"}, 32'(bus_if.bus_read_out), 32'd0);
        chk({tag, "_wr"}, 32'(bus_if.bus_write_out), 32'd0);
        chk({tag, "_stall"}, 32'(stall_out), 32'd0);
        chk({tag, "_rvalid"}, 32'(rdata_valid_out), 32'd0);
    endtask

    // One access: waits = BUSY cycles without ready before ready arrives.
    task automatic do_access(input bit rd, input bit wr, input bit fence, input logic [2:0] width,
                             input bit zext, input logic [31:0] addr, input logic [31:0] wdata,
                             input int waits, input logic [31:0] rdata, input bit bfault);
        bit req, misal, hit, efault;
        int sz, nbusy;
        logic [31:0] erdata;
        sz     = size_of(width);
        req    = rd | wr;
        misal  = (addr % sz) != 0;
        hit    = waits < T;
        nbusy  = hit ? waits + 1 : T;
        efault = hit ? bfault : 1'b1;
        erdata = (efault || wr) ? 32'd0 : exp_load(rdata, addr, width, zext);

        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; mem_fence_in = fence;
        mem_width_in = width; mem_zero_extend_in = zext; addr_in = addr; wdata_in = wdata;
        bus_if.bus_ready_in = 1'b0; bus_if.bus_fault_in = 1'b0;
        @(negedge clk);
        chk("acc_stall", 32'(stall_out), 32'(req && !misal));
        chk("acc_misal", 32'(misaligned_out), 32'(req && misal));
        chk("acc_rvalid", 32'(rdata_valid_out), 32'd0);
        if (!req || misal) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(negedge clk);
            chk_idle_bus("noacc");
            return;
        end
        for (int i = 1; i <= nbusy; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            bus_if.bus_ready_in = hit && (i == nbusy);
            bus_if.bus_rdata_in = bus_if.bus_ready_in ? rdata : $urandom;
            bus_if.bus_fault_in = bus_if.bus_ready_in ? bfault : 1'($urandom);
            @(negedge clk);
            chk("busy_rd", 32'(bus_if.bus_read_out), 32'(!wr));
            chk("busy_wr", 32'(bus_if.bus_write_out), 32'(wr));
            chk("busy_addr", bus_if.bus_addr_out, addr & 32'hFFFF_FFFC);
            chk("busy_mask", 32'(bus_if.bus_wmask_out), wr ? 32'(exp_mask(addr, width)) : 32'd0);
            if (wr) chk("busy_wdata", bus_if.bus_wdata_out, exp_wdata(wdata, width));
            chk("busy_stall", 32'(stall_out), 32'd1);
            chk("busy_rvalid", 32'(rdata_valid_out), 32'd0);
        end
        @(posedge clk); #1;
        bus_if.bus_ready_in = 1'($urandom);
        bus_if.bus_fault_in = 1'($urandom);
        bus_if.bus_rdata_in = $urandom;
        @(negedge clk);
        chk("resp_rvalid", 32'(rdata_valid_out), 32'd1);
        chk("resp_fault", 32'(fault_out), 32'(efault));
        chk("resp_rdata", rdata_out, erdata);
        chk("resp_stall", 32'(stall_out), 32'd0);
        chk("resp_rd", 32'(bus_if.bus_read_out), 32'd0);
        chk("resp_wr", 32'(bus_if.bus_write_out), 32'd0);
        bus_if.bus_ready_in = 1'b0;
        bus_if.bus_fault_in = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        int sel;
        bus_if.bus_rdata_in = 32'd0;
        bus_if.bus_ready_in = 1'b0;
        bus_if.bus_fault_in = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_rvalid", 32'(rdata_valid_out), 32'd0);
        chk("rst_misal", 32'(misaligned_out), 32'd0);
        chk("rst_fault", 32'(fault_out), 32'd0);
        chk("rst_addr", bus_if.bus_addr_out, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata_out, 32'd0);
        chk("rst_mask", 32'(bus_if.bus_wmask_out), 32'd0);
        chk_idle_bus("rst");
        #1 reset = 1'b0;

        do_access(1, 0, 0, 3'd2, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 0);
        do_access(1, 0, 0, 3'd0, 0, 32'h103, 32'h0, 1, 32'h80AA_BBCC, 0);
        do_access(1, 0, 0, 3'd0, 1, 32'h103, 32'h0, 0, 32'h80AA_BBCC, 0);
        do_access(1, 0, 0, 3'd1, 0, 32'h102, 32'h0, 2, 32'h80AA_BBCC, 0);
        do_access(0, 1, 0, 3'd1, 0, 32'h202, 32'hABCD_1234, 0, 32'h0, 0);
        do_access(0, 1, 0, 3'd0, 0, 32'h201, 32'h0000_0056, 1, 32'h0, 0);
        do_access(1, 0, 0, 3'd2, 0, 32'h101, 32'h0, 0, 32'h0, 0);
        do_access(1, 0, 0, 3'd2, 0, 32'h400, 32'h0, 100, 32'h1111_2222, 0);
        do_access(1, 0, 0, 3'd2, 0, 32'h404, 32'h0, 0, 32'h3333_4444, 1);
        do_access(0, 0, 1, 3'd2, 0, 32'h500, 32'h0, 0, 32'h0, 0);
        do_access(1, 1, 1, 3'd2, 0, 32'h600, 32'hCAFE_F00D, 0, 32'h5555_6666, 0);
        do_access(1, 0, 0, 3'd5, 0, 32'h608, 32'h0, T - 1, 32'h8765_4321, 0);
        do_access(1, 0, 0, 3'd6, 0, 32'h60A, 32'h0, 0, 32'h0, 0);

        // Reset during the second BUSY cycle of a store that would wait 3 cycles.
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b1; mem_fence_in = 1'b0;
        mem_width_in = 3'd2; addr_in = 32'h300; wdata_in = 32'h1234_5678;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("rstbusy_wr1", 32'(bus_if.bus_write_out), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstbusy_wr2", 32'(bus_if.bus_write_out), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle_bus("rstbusy_after");
        repeat (3) begin
            @(posedge clk); #1;
            bus_if.bus_ready_in = 1'b1;
            @(negedge clk);
            chk("rstbusy_noresp", 32'(rdata_valid_out), 32'd0);
        end
        bus_if.bus_ready_in = 1'b0;
        do_access(1, 0, 0, 3'd2, 0, 32'h304, 32'h0, 0, 32'h0BAD_F00D, 0);

        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            sel = $urandom_range(0, 7);
            do_access(sel == 1 || (sel >= 2 && sel <= 4), sel == 1 || sel >= 5,
                      $urandom_range(0, 3) == 0, 3'($urandom_range(0, 4)),
                      1'($urandom), ra, $urandom, $urandom_range(0, T + 1),
                      $urandom, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store engine for the RISC-V core. Consumes the memory control fields produced by the decoder (read, write, width, zero-extend, fence) plus the ALU-computed address and store data. Issues single-beat transactions on the data bus, aligns store data and byte enables, extracts and sign- or zero-extends load data, and stalls the pipeline while a transaction is outstanding. At most one transaction is outstanding at a time.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles waited for `bus_ready_in` before the transaction is abandoned with a fault; range 1..255.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  the memory-stage instruction is valid this cycle.
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- mem_width_in  in  3  0 = byte, 1 = half, 2 = word; other values are illegal and treated as word.
- mem_zero_extend_in  in  1  load zero-extends when 1 and sign-extends when 0.
- mem_fence_in  in  1  fence.
- addr_in  in  32  byte address.
- wdata_in  in  32  store data; the low bytes are used for byte and half stores.
- stall_out  out  1  holds the pipeline.
- rdata_out  out  32  extended load result.
- rdata_valid_out  out  1  single-cycle completion strobe for both loads and stores.
- misaligned_out  out  1  misaligned access trap request.
- fault_out  out  1  bus error or timeout trap request, valid together with `rdata_valid_out`.
- bus_addr_out  out  32  word-aligned address, `{addr[31:2], 2'b00}`.
- bus_read_out, bus_write_out  out  1  request strobes.
- bus_wdata_out  out  32  lane-replicated store data.
- bus_wmask_out  out  4  byte enables; 0 for reads.
- bus_rdata_in  in  32  read data, valid when `bus_ready_in` is 1.
- bus_ready_in  in  1  completes the current request.
- bus_fault_in  in  1  error response, sampled with `bus_ready_in`.

## Operation
- States:
  - IDLE: accepting requests.
  - BUSY: request on the bus.
  - RESP: one-cycle completion.
- **Accept.** Condition: IDLE, `valid_in`, read or write asserted, and the access is aligned.
  - Latch the aligned address, wdata, wmask, width, extend mode and `addr[1:0]`.
  - Go to BUSY.
  - If read and write are both set, the access is a store.
- **Misaligned access.** Half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - No bus activity and no stall.
  - `misaligned_out` = 1 combinationally in that cycle.
  - State stays IDLE.
- **Fence.** Completes in IDLE with no stall, because nothing can be outstanding there.
  - A fence arriving with a read or write is treated as that access.
- **Store lanes.**
  - Byte: wmask = `4'b0001 << addr[1:0]`; wdata = the byte replicated ×4.
  - Half: wmask = `4'b0011 << {addr[1],1'b0}`; wdata = the half replicated ×2.
  - Word: wmask = `4'b1111`.
- **Load extract.**
  - Lane = `bus_rdata_in >> (8*addr[1:0])`, using the low 8 or 16 bits.
  - Extend to 32 bits per the latched zero-extend bit.
  - Word loads pass through unchanged.
- **BUSY.**
  - `bus_read_out` or `bus_write_out` is held together with addr, wdata and mask, all stable until `bus_ready_in`.
  - A timeout counter starts at 0 on entry and increments each BUSY cycle.
  - On `bus_ready_in`: capture the extended data and `bus_fault_in`, drop the strobes, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without ready: drop the strobes, set the fault, go to RESP.
- **RESP.**
  - `rdata_valid_out` = 1; `fault_out` = the captured fault.
  - `rdata_out` = the captured data; it is 0 for stores and for faults.
  - Next state is IDLE.

## Timing
- **Reset.**
  - State IDLE and counter 0.
  - All outputs 0: `stall_out`, `rdata_out`, `rdata_valid_out`, `misaligned_out`, `fault_out`, all bus outputs.
  - Reset asserted in BUSY drops the bus strobes on the next edge. The abandoned transaction produces no response.
- **stall_out.**
  - Combinational.
  - 1 in the accept cycle and in every BUSY cycle.
  - 0 in RESP and in IDLE otherwise.
- **Bus strobes.** Registered: first asserted in the cycle after accept.
- **Minimum latency.** With ready in the first BUSY cycle:
  - accept at cycle 0, BUSY at cycle 1, RESP at cycle 2.
  - The pipeline stalls for 2 cycles.
- **Each wait cycle** adds one cycle to both the latency and the stall.
- **Inputs ignored** in BUSY and RESP, so the pipeline must hold them.
- **Back-to-back.** A new request is accepted in the IDLE cycle immediately after RESP.
- **Bus ready** outside BUSY is ignored.
- **Timeout.** With no ready, RESP occurs at cycle TIMEOUT_CYCLES+1 after accept.

## Test plan
- Word load at addr 0x100; ready on the first BUSY cycle with rdata 0xDEADBEEF -> `bus_read_out` high for one cycle with `bus_addr_out` = 0x100; at cycle 2, `rdata_valid_out` = 1 and `rdata_out` = 0xDEADBEEF; stall high for cycles 0–1.
- Byte load at addr 0x103, rdata 0x80AABBCC -> signed gives 0xFFFFFF80; zero-extend gives 0x00000080. Half load at 0x102, signed, same rdata -> 0xFFFF80AA.
- Half store of 0x1234 at 0x202 -> wmask 4'b1100, wdata 0x12341234, addr 0x200. Byte store of 0x56 at 0x201 -> wmask 4'b0010, wdata 0x56565656.
- Word load at 0x101 -> `misaligned_out` = 1 in the same cycle; no bus strobe; no stall.
- Load with ready held low and TIMEOUT_CYCLES = 4 -> strobe high for 4 cycles, then RESP with `fault_out` = 1 and `rdata_out` = 0. A separate load with ready and `bus_fault_in` both asserted -> `fault_out` = 1.
- Reset asserted in the second BUSY cycle of a 3-wait store -> strobes low after that edge; no `rdata_valid_out`; the next request accepts normally.
